// File: rtl/dineflow_pkg.sv
// Shared constants and types for the Dineflow order engine: menu prices,
// kitchen preparation times and the per-table kitchen state.
package dineflow_pkg;

   localparam int unsigned PRICE_W = 8;
   localparam int unsigned PREP_W  = 8;

   // Index 0 is the rightmost element: item 0 costs 10 and cooks for 3 cycles
   localparam logic [3:0][PRICE_W-1:0] PRICE     = {8'd40, 8'd30, 8'd20, 8'd10};
   localparam logic [3:0][PREP_W-1:0]  PREP_TIME = {8'd9, 8'd7, 8'd5, 8'd3};

   typedef enum logic [1:0] {
      IDLE,
      COOK,
      READY
   } kitchen_state_t;

endpackage

// File: rtl/dineflow_order_fifo.sv
// Per-table order queue: circular buffer of item codes with an occupancy count
// and full/empty flags decoded from that count.
module dineflow_order_fifo
   import dineflow_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned W     = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dineflow_order_engine.sv
// Dineflow order engine: shared inventory with lowest-table-first admission,
// per-table order queue, kitchen timer FSM and saturating bill.
// Optional inventory restocking is built when DINEFLOW_RESTOCK_EN is defined.
module dineflow_order_engine
   import dineflow_pkg::*;
#(
   parameter int unsigned NUM_TABLES  = 2,
   parameter int unsigned QUEUE_DEPTH = 16,
   parameter int unsigned ITEM_W      = 2,
   parameter int unsigned INV_W       = 4,
   parameter int unsigned INV_INIT    = 5,
   parameter int unsigned BILL_W      = 12,
   parameter int unsigned TIMER_W     = 8
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic [NUM_TABLES-1:0]                           order_valid,
   input  logic [NUM_TABLES*ITEM_W-1:0]                    order_item,
   output logic [NUM_TABLES-1:0]                           order_accept,
   output logic [NUM_TABLES-1:0]                           order_reject,
   output logic [NUM_TABLES*($clog2(QUEUE_DEPTH)+1)-1:0]   queue_size,
   output logic [NUM_TABLES-1:0]                           item_ready,
   output logic [NUM_TABLES*ITEM_W-1:0]                    ready_item,
   input  logic [NUM_TABLES-1:0]                           item_ack,
   output logic [NUM_TABLES*BILL_W-1:0]                    bill,
   input  logic [NUM_TABLES-1:0]                           bill_clear,
   input  logic                                            restock_valid,
   input  logic [ITEM_W-1:0]                               restock_item,
   input  logic [INV_W-1:0]                                restock_qty
);

   localparam int unsigned NUM_ITEMS = 2 ** ITEM_W;
   localparam int unsigned CNT_W     = $clog2(QUEUE_DEPTH) + 1;
   localparam int unsigned SUM_W     = BILL_W + PRICE_W;

   logic [INV_W-1:0]      inv      [NUM_ITEMS];
   logic [INV_W-1:0]      avail    [NUM_ITEMS];
   logic [INV_W-1:0]      inv_next [NUM_ITEMS];
   logic [NUM_TABLES-1:0] accept_c;
   logic [NUM_TABLES-1:0] full;
   logic [NUM_TABLES-1:0] empty;
   logic [NUM_TABLES-1:0] pop;
   logic [ITEM_W-1:0]     sel_item;

   // Walk tables lowest index first; each accept consumes one unit so later tables see the remainder
   always_comb begin
      avail    = inv;
      accept_c = '0;
      sel_item = '0;
      for (int t = 0; t < NUM_TABLES; t++) begin
         sel_item = order_item[t*ITEM_W +: ITEM_W];
         if (order_valid[t] && !full[t] && (avail[sel_item] != '0)) begin
            accept_c[t]     = 1'b1;
            avail[sel_item] = avail[sel_item] - INV_W'(1);
         end
      end
   end

`ifdef DINEFLOW_RESTOCK_EN
   logic [INV_W:0] restock_sum;

   // Restock lands on the post-consumption value, so admission never sees it this cycle
   always_comb begin
      inv_next    = avail;
      restock_sum = {1'b0, avail[restock_item]} + {1'b0, restock_qty};
      if (restock_valid) begin
         inv_next[restock_item] = restock_sum[INV_W] ? '1 : restock_sum[INV_W-1:0];
      end
   end
`else
   logic unused_restock;

   assign unused_restock = ^{restock_valid, restock_item, restock_qty};

   always_comb begin
      inv_next = avail;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_ITEMS; i++) inv[i] <= INV_W'(INV_INIT);
      end else begin
         for (int i = 0; i < NUM_ITEMS; i++) inv[i] <= inv_next[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         order_accept <= '0;
         order_reject <= '0;
      end else begin
         order_accept <= accept_c;
         order_reject <= order_valid & ~accept_c;
      end
   end

   for (genvar t = 0; t < NUM_TABLES; t++) begin : g_table
      kitchen_state_t      state;
      logic [TIMER_W-1:0]  timer;
      logic [ITEM_W-1:0]   cur_item;
      logic [ITEM_W-1:0]   head;
      logic [ITEM_W-1:0]   ord_item;
      logic                ready_q;
      logic [ITEM_W-1:0]   ready_item_q;
      logic [BILL_W-1:0]   bill_q;
      logic [PRICE_W-1:0]  ord_price;
      logic [SUM_W-1:0]    bill_sum;

      assign ord_item  = order_item[t*ITEM_W +: ITEM_W];
      assign pop[t]    = (state == IDLE) && !empty[t];
      assign ord_price = PRICE[2'(ord_item)];
      assign bill_sum  = SUM_W'(bill_q) + SUM_W'(ord_price);

      assign item_ready[t]                   = ready_q;
      assign ready_item[t*ITEM_W +: ITEM_W]  = ready_item_q;
      assign bill[t*BILL_W +: BILL_W]        = bill_q;

      dineflow_order_fifo #(
         .DEPTH (QUEUE_DEPTH),
         .W     (ITEM_W)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .push      (accept_c[t]),
         .push_data (ord_item),
         .pop       (pop[t]),
         .head      (head),
         .count     (queue_size[t*CNT_W +: CNT_W]),
         .full      (full[t]),
         .empty     (empty[t])
      );

      // Kitchen: pop into COOK, count down, hold in READY until picked up
      always_ff @(posedge clk) begin
         if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            cur_item     <= '0;
            ready_q      <= 1'b0;
            ready_item_q <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (!empty[t]) begin
                     state    <= COOK;
                     cur_item <= head;
                     timer    <= TIMER_W'(PREP_TIME[2'(head)]);
                  end
               end
               COOK: begin
                  if (timer == TIMER_W'(1)) begin
                     state        <= READY;
                     ready_q      <= 1'b1;
                     ready_item_q <= cur_item;
                  end else begin
                     timer <= timer - TIMER_W'(1);
                  end
               end
               READY: begin
                  if (item_ack[t]) begin
                     state        <= IDLE;
                     ready_q      <= 1'b0;
                     ready_item_q <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end

      // A clear coinciding with an accept leaves just the new item's price
      always_ff @(posedge clk) begin
         if (reset) begin
            bill_q <= '0;
         end else if (bill_clear[t]) begin
            bill_q <= accept_c[t] ? BILL_W'(ord_price) : '0;
         end else if (accept_c[t]) begin
            bill_q <= (|bill_sum[SUM_W-1:BILL_W]) ? '1 : BILL_W'(bill_sum);
         end
      end
   end

endmodule

// File: tb/tb_dineflow_order_engine.sv
// Directed bench for dineflow_order_engine: a vector table on a default
// two-table engine plus hand sequences on a small-queue, narrow-bill engine.
module tb_dineflow_order_engine;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   // Default-parameter engine
   logic [1:0]  order_valid;
   logic [3:0]  order_item;
   logic [1:0]  order_accept;
   logic [1:0]  order_reject;
   logic [9:0]  queue_size;
   logic [1:0]  item_ready;
   logic [3:0]  ready_item;
   logic [1:0]  item_ack;
   logic [23:0] bill;
   logic [1:0]  bill_clear;
   logic        restock_valid;
   logic [1:0]  restock_item;
   logic [3:0]  restock_qty;

   // Single table, depth 4, inventory 15, 6-bit bill
   logic       s_order_valid;
   logic [1:0] s_order_item;
   logic       s_order_accept;
   logic       s_order_reject;
   logic [2:0] s_queue_size;
   logic       s_item_ready;
   logic [1:0] s_ready_item;
   logic       s_item_ack;
   logic [5:0] s_bill;
   logic       s_bill_clear;
   logic       s_restock_valid;
   logic [1:0] s_restock_item;
   logic [3:0] s_restock_qty;

   int n_total = 0;
   int n_pass  = 0;

   dineflow_order_engine #(
      .NUM_TABLES(2), .QUEUE_DEPTH(16), .ITEM_W(2), .INV_W(4),
      .INV_INIT(5), .BILL_W(12), .TIMER_W(8)
   ) dut (
      .clk(clk), .reset(reset),
      .order_valid(order_valid), .order_item(order_item),
      .order_accept(order_accept), .order_reject(order_reject),
      .queue_size(queue_size), .item_ready(item_ready), .ready_item(ready_item),
      .item_ack(item_ack), .bill(bill), .bill_clear(bill_clear),
      .restock_valid(restock_valid), .restock_item(restock_item), .restock_qty(restock_qty)
   );

   dineflow_order_engine #(
      .NUM_TABLES(1), .QUEUE_DEPTH(4), .ITEM_W(2), .INV_W(4),
      .INV_INIT(15), .BILL_W(6), .TIMER_W(8)
   ) dut_s (
      .clk(clk), .reset(reset),
      .order_valid(s_order_valid), .order_item(s_order_item),
      .order_accept(s_order_accept), .order_reject(s_order_reject),
      .queue_size(s_queue_size), .item_ready(s_item_ready), .ready_item(s_ready_item),
      .item_ack(s_item_ack), .bill(s_bill), .bill_clear(s_bill_clear),
      .restock_valid(s_restock_valid), .restock_item(s_restock_item), .restock_qty(s_restock_qty)
   );

   typedef struct {
      logic [1:0]  ov;
      logic [3:0]  oi;
      logic [1:0]  ack;
      logic [1:0]  clr;
      logic [1:0]  acc;
      logic [1:0]  rej;
      logic [9:0]  qs;
      logic [1:0]  rdy;
      logic [3:0]  ri;
      logic [23:0] bl;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int ov, input int it1, input int it0, input int ack,
                               input int clr, input int acc, input int rej, input int q1,
                               input int q0, input int rdy, input int ri1, input int ri0,
                               input int b1, input int b0);
      vec_t v;
      v.ov  = 2'(ov);
      v.oi  = {2'(it1), 2'(it0)};
      v.ack = 2'(ack);
      v.clr = 2'(clr);
      v.acc = 2'(acc);
      v.rej = 2'(rej);
      v.qs  = {5'(q1), 5'(q0)};
      v.rdy = 2'(rdy);
      v.ri  = {2'(ri1), 2'(ri0)};
      v.bl  = {12'(b1), 12'(b0)};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic s_step(input int c, input logic ov, input logic [1:0] it, input logic ack,
                         input logic clr, input logic e_acc, input logic e_rej, input int e_q,
                         input int e_bill, input logic e_rdy);
      s_order_valid = ov;
      s_order_item  = it;
      s_item_ack    = ack;
      s_bill_clear  = clr;
      tick();
      chk($sformatf("small c%0d accept", c), 32'(s_order_accept), 32'(e_acc));
      chk($sformatf("small c%0d reject", c), 32'(s_order_reject), 32'(e_rej));
      chk($sformatf("small c%0d queue_size", c), 32'(s_queue_size), 32'(e_q));
      chk($sformatf("small c%0d bill", c), 32'(s_bill), 32'(e_bill));
      chk($sformatf("small c%0d item_ready", c), 32'(s_item_ready), 32'(e_rdy));
   endtask

   initial begin
      int n_acc;

      reset = 1'b1;
      order_valid = '0; order_item = '0; item_ack = '0; bill_clear = '0;
      restock_valid = 1'b0; restock_item = '0; restock_qty = '0;
      s_order_valid = 1'b0; s_order_item = '0; s_item_ack = 1'b0; s_bill_clear = 1'b0;
      s_restock_valid = 1'b0; s_restock_item = '0; s_restock_qty = '0;

      // ov it1 it0 ack clr | acc rej q1 q0 rdy ri1 ri0 b1 b0
      vecs.push_back(mk(3, 1, 0, 0, 0,  3, 0, 1, 1, 0, 0, 0,  20, 10));
      vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0,  20, 20));
      vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 2, 0, 0, 0,  20, 30));
      vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 3, 0, 0, 0,  20, 40));
      vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 4, 1, 0, 0,  20, 50));
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 4, 1, 0, 0,  20, 50));
      vecs.push_back(mk(0, 0, 0, 1, 0,  0, 0, 0, 4, 2, 1, 0,  20, 50));
      vecs.push_back(mk(0, 0, 0, 3, 0,  0, 0, 0, 3, 0, 0, 0,  20, 50));
      vecs.push_back(mk(2, 3, 0, 0, 2,  2, 0, 1, 3, 0, 0, 0,  40, 50));
      vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 3, 0, 0, 0,  40, 0));
      vecs.push_back(mk(2, 2, 0, 0, 0,  2, 0, 1, 3, 1, 0, 0,  70, 0));
      vecs.push_back(mk(2, 2, 0, 0, 0,  2, 0, 2, 3, 1, 0, 0, 100, 0));
      vecs.push_back(mk(2, 2, 0, 0, 0,  2, 0, 3, 3, 1, 0, 0, 130, 0));
      vecs.push_back(mk(2, 2, 0, 0, 0,  2, 0, 4, 3, 1, 0, 0, 160, 0));
      vecs.push_back(mk(3, 2, 2, 0, 0,  1, 2, 4, 4, 1, 0, 0, 160, 30));
      vecs.push_back(mk(3, 3, 2, 0, 0,  2, 1, 5, 4, 1, 0, 0, 200, 30));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 5, 4, 1, 0, 0, 200, 30));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 5, 4, 1, 0, 0, 200, 30));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 5, 4, 3, 3, 0, 200, 30));
      vecs.push_back(mk(0, 0, 0, 2, 0,  0, 0, 5, 4, 1, 0, 0, 200, 30));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 4, 4, 1, 0, 0, 200, 30));

      tick();
      tick();
      chk("reset accept", 32'(order_accept), 32'd0);
      chk("reset reject", 32'(order_reject), 32'd0);
      chk("reset queue_size", 32'(queue_size), 32'd0);
      chk("reset item_ready", 32'(item_ready), 32'd0);
      chk("reset bill", 32'(bill), 32'd0);
      chk("reset small queue_size", 32'(s_queue_size), 32'd0);
      chk("reset small bill", 32'(s_bill), 32'd0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         order_valid = vecs[i].ov;
         order_item  = vecs[i].oi;
         item_ack    = vecs[i].ack;
         bill_clear  = vecs[i].clr;
         tick();
         chk($sformatf("vec%0d accept", i + 1), 32'(order_accept), 32'(vecs[i].acc));
         chk($sformatf("vec%0d reject", i + 1), 32'(order_reject), 32'(vecs[i].rej));
         chk($sformatf("vec%0d queue_size", i + 1), 32'(queue_size), 32'(vecs[i].qs));
         chk($sformatf("vec%0d item_ready", i + 1), 32'(item_ready), 32'(vecs[i].rdy));
         chk($sformatf("vec%0d bill", i + 1), 32'(bill), 32'(vecs[i].bl));
         for (int t = 0; t < 2; t++) begin
            if (vecs[i].rdy[t])
               chk($sformatf("vec%0d ready_item t%0d", i + 1, t),
                   32'(ready_item[t*2 +: 2]), 32'(vecs[i].ri[t*2 +: 2]));
         end
      end
      order_valid = '0; order_item = '0; item_ack = '0; bill_clear = '0;

      // Fill to depth 4 with one item parked in READY, then full-queue and saturation corners
      s_step(1,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 10, 1'b0);
      s_step(2,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 20, 1'b0);
      s_step(3,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 30, 1'b0);
      s_step(4,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 40, 1'b0);
      s_step(5,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 50, 1'b1);
      s_step(6,  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 50, 1'b1);
      s_step(7,  1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 50, 1'b0);
      s_step(8,  1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3, 50, 1'b0);
      s_step(9,  1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4, 63, 1'b0);
      s_step(10, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 4, 0,  1'b0);
      s_order_valid = 1'b0; s_bill_clear = 1'b0;

      // Reset with work queued, cooking and ready
      reset = 1'b1;
      tick();
      chk("midreset accept", 32'(order_accept), 32'd0);
      chk("midreset queue_size", 32'(queue_size), 32'd0);
      chk("midreset item_ready", 32'(item_ready), 32'd0);
      chk("midreset bill", 32'(bill), 32'd0);
      chk("midreset small queue_size", 32'(s_queue_size), 32'd0);
      reset = 1'b0;

      // Item 2 was exhausted before reset; it must be back at full stock
      order_valid = 2'b01; order_item = 4'b0010;
      tick();
      chk("post-reset item2 accept", 32'(order_accept), 32'd1);
      chk("post-reset queue_size", 32'(queue_size), 32'd1);
      chk("post-reset bill", 32'(bill), 32'd30);

      // Drain item 0 to zero
      order_valid = 2'b11; order_item = 4'b0000;
      tick();
      chk("drain0 a accept", 32'(order_accept), 32'd3);
      tick();
      chk("drain0 b accept", 32'(order_accept), 32'd3);
      order_valid = 2'b01;
      tick();
      chk("drain0 c accept", 32'(order_accept), 32'd1);

      // Restock in the same cycle as an order: admission sees the old, empty count
      restock_valid = 1'b1; restock_item = 2'd0; restock_qty = 4'd3;
      tick();
      chk("restock same-cycle reject", 32'(order_reject), 32'd1);
      restock_valid = 1'b0;
      tick();
`ifdef DINEFLOW_RESTOCK_EN
      chk("after restock accept", 32'(order_accept), 32'd1);

      order_valid = 2'b00; item_ack = 2'b11;
      restock_valid = 1'b1; restock_qty = 4'd15;
      tick();
      restock_valid = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 16; i++) begin
         order_valid = (i % 2 == 0) ? 2'b01 : 2'b10;
         tick();
         if (order_accept[i % 2]) n_acc++;
      end
      chk("saturated inventory accepts", 32'(n_acc), 32'd15);
      chk("saturated inventory last reject", 32'(order_reject), 32'd2);
`else
      n_acc = 0;
      chk("restock ignored reject", 32'(order_reject), 32'd1);
`endif
      order_valid = '0; item_ack = '0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dineflow_order_engine.md
# dineflow_order_engine

Parametrised order engine for the Dineflow restaurant controller, for an arbitrary number of tables. Per table it provides:
- order admission against a shared item inventory,
- a bounded order FIFO,
- a kitchen preparation timer with a ready/acknowledge pickup handshake,
- a saturating running bill with clear.

It sits between the table order terminals and the serving/billing front end.

## Interface
Parameters:
- NUM_TABLES, 2, number of tables (≥1)
- QUEUE_DEPTH, 16, per-table FIFO entries (power of two, ≥2)
- ITEM_W, 2, item code width; NUM_ITEMS = 2**ITEM_W
- INV_W, 4, inventory counter width per item
- INV_INIT, 5, inventory value per item after reset
- BILL_W, 12, bill width per table
- TIMER_W, 8, prep timer width

Ports (per-table buses are packed, table t occupies slice t):
- clk  in  1  clock
- reset  in  1  synchronous reset; polarity and synchronicity fixed: synchronous, active-high
- order_valid  in  NUM_TABLES  order request, one cycle per order
- order_item  in  NUM_TABLES*ITEM_W  item code
- order_accept  out  NUM_TABLES  registered accept pulse
- order_reject  out  NUM_TABLES  registered reject pulse
- queue_size  out  NUM_TABLES*($clog2(QUEUE_DEPTH)+1)  orders waiting in FIFO
- item_ready  out  NUM_TABLES  finished item waiting for pickup
- ready_item  out  NUM_TABLES*ITEM_W  code of finished item
- item_ack  in  NUM_TABLES  pickup acknowledge
- bill  out  NUM_TABLES*BILL_W  running bill
- bill_clear  in  NUM_TABLES  zero the bill (payment taken)
- restock_valid  in  1  restock request (only with DINEFLOW_RESTOCK_EN)
- restock_item  in  ITEM_W  item to restock
- restock_qty  in  INV_W  quantity to add

## Operation
- **Reset:**
  - All outputs are 0.
  - FIFOs are empty and every kitchen FSM is in IDLE.
  - Every inventory counter is INV_INIT.
  - A reset mid-operation discards queued, cooking and ready items, and clears the bills.
- **Admission:** order_valid[t] is accepted iff queue_size[t] < QUEUE_DEPTH and inventory[item] > 0 after higher-priority claims.
  - Priority goes by table index, lowest first.
  - When k units remain and more than k tables request the same item, the k lowest-indexed tables are accepted.
  - Fullness uses the size before this cycle's pop: a full queue rejects even if the kitchen pops the same cycle.
- **On accept:**
  - The item is pushed to the FIFO tail.
  - inventory[item] is decremented.
  - bill[t] += PRICE[item], saturating at 2**BILL_W-1.
- **On reject:** nothing changes except the order_reject pulse.
- **bill_clear:** bill_clear[t] sets bill[t] to 0. If an accept occurs in the same cycle, bill[t] = PRICE[item].
- **Kitchen FSM (per table), states IDLE, COOK, READY:**
  - IDLE → COOK when the FIFO is non-empty: pop the head and set timer = PREP_TIME[item].
  - COOK: the timer decrements every cycle. COOK → READY on the edge where timer == 1.
  - READY: item_ready = 1 and ready_item = the held item. READY → IDLE on item_ack; there is no pop in that same cycle.
  - item_ack outside READY is ignored.
- **Constants:** PRICE = {10, 20, 30, 40} and PREP_TIME = {3, 5, 7, 9} for items 0..3. For NUM_ITEMS > 4, the item code wraps mod 4 into the tables. PREP_TIME ≥ 1.
- **Pointers:** FIFO pointers are $clog2(QUEUE_DEPTH) bits and wrap naturally. Simultaneous push and pop leaves queue_size unchanged.

## Timing
- order_valid sampled at edge E:
  - order_accept/order_reject are high for exactly the cycle after E.
  - queue_size and bill update after E.
- Into an empty FIFO with the kitchen IDLE:
  - pop at E+1;
  - item_ready rises after edge E+1+PREP_TIME[item].
- item_ack sampled at edge A: item_ready is low after A. The next pop happens at A+1 at the earliest.
- Inventory updates after the accept edge and is visible to the next cycle's admission.

## Configuration
- **With DINEFLOW_RESTOCK_EN defined:**
  - restock_valid adds restock_qty to inventory[restock_item], saturating at 2**INV_W-1.
  - When a restock and a consumption of the same item happen in the same cycle, the result is inv + qty − consumed, saturated.
  - Admission in that cycle uses the pre-restock value.
- **Without it:**
  - The restock ports remain but are ignored.
  - Inventory only decrements; no restock logic is synthesised.

## Structure
- **Package dineflow_pkg:** PRICE and PREP_TIME constant arrays, and the kitchen state typedef (IDLE/COOK/READY).
- **Sub-module dineflow_order_fifo:** push/pop, count and full/empty outputs, parametrised by depth and ITEM_W. Instantiated NUM_TABLES times.
- **Top level:** shared inventory, priority admission, per-table FSM, timer and bill.

## Test plan
1. Reset with defaults → bill 0, queue_size 0, item_ready 0. Five orders of item 0 on table 0 are accepted; the sixth is rejected.
2. Table 0 orders item 1 at edge E → order_accept after E, bill 20, item_ready with ready_item 1 after edge E+6. item_ack → item_ready low after the ack edge.
3. Inventory of item 2 at 1; both tables order item 2 in the same cycle → table 0 accepted, table 1 rejected, inventory 0.
4. QUEUE_DEPTH=4, INV_INIT=15, no item_ack → the kitchen holds one item in READY, four more are queued (queue_size 4), and the next order is rejected.
5. bill_clear in the same cycle as an accepted item 3 order → bill 40. Repeated orders with BILL_W=6 → bill saturates at 63.
6. With DINEFLOW_RESTOCK_EN: item 0 inventory 0, restock qty 3 → the next order is accepted and inventory becomes 2. Restock qty 15 at inventory 2 → inventory saturates at 15.
